lfsr_crc_ctrl: RTL
==================

# lfsr_crc_ctrl

Sequencing controller for the parallel Galois LFSR step: accepts a seeded packet stream N bits per beat over a valid/ready handshake, and advances a WIDTH-bit LFSR register once per accepted beat. It presents the final signature (CRC) with a hold-until-taken handshake. It sits between a packet source and any consumer of the per-packet CRC or scrambler state.

## Interface
- WIDTH, 16: LFSR width in bits.
- N, 16: data bits consumed per beat.
- POLY, 16'h6801: Galois feedback taps (WIDTH bits).
- XOROUT, 16'h0000: XOR mask applied to the final signature.
- clk  in  1: clock; all state updates on rising edge.
- rst_b  in  1: asynchronous active-low reset.
- start  in  1: begin packet; sampled only in IDLE.
- seed  in  WIDTH: initial LFSR value, captured with start.
- abort  in  1: drop current packet, return to IDLE.
- s_valid  in  1: data beat valid.
- s_ready  out  1: controller can accept a beat.
- s_data  in  N: data beat, MSB consumed first.
- s_last  in  1: final beat of packet.
- crc_valid  out  1: signature available.
- crc_ready  in  1: consumer takes signature.
- crc_out  out  WIDTH: signature, equal to state XOR XOROUT.
- beat_cnt  out  16: beats accepted in current/last packet, saturating at 16'hFFFF.

## Operation
- Serial reference step per data bit d: fb = state[WIDTH-1] ^ d; state = {state[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0). One beat equals N such steps, s_data[N-1] first.
- FSM states: IDLE, RUN, DONE.
- IDLE: s_ready=0, crc_valid=0. On start: state<=seed, beat_cnt<=0, go to RUN.
- RUN: s_ready=1. On s_valid&&s_ready: state<=step(state,s_data), beat_cnt<=beat_cnt+1 (saturating). If s_last is also set, go to DONE.
- DONE: crc_valid=1, crc_out=state^XOROUT, held stable. On crc_ready: go to IDLE. beat_cnt holds until the next start.
- abort, any state: go to IDLE next edge. A beat presented in the same cycle is not accepted (s_ready is forced 0 when abort=1). Priority order: abort > s_last > ordinary beat.
- start outside IDLE is ignored. start together with abort in IDLE: abort wins, stay IDLE.
- s_data, s_last are don't-care when s_valid=0.

## Timing
- Reset values: state=0, FSM=IDLE, s_ready=0, crc_valid=0, crc_out=XOROUT, beat_cnt=0.
- start at edge k: s_ready=1 from cycle k+1.
- Throughput: one beat per cycle in RUN; no bubbles between beats.
- Latency: last beat accepted at edge k gives crc_valid=1 in cycle k+1 (registered).
- 1-beat packet: start at k, beat+last at k+1, crc_valid at k+2.
- crc_valid&&crc_ready at edge k: IDLE in cycle k+1. A new start is accepted at edge k+1 or later, so minimum packet turnaround is 1 idle cycle.
- s_ready and crc_valid are derived from registered FSM state only, with no combinational path from s_valid or crc_ready.
- rst_b asserted mid-packet: immediate return to reset values; partial signature discarded.

## Structure
- Package lfsr_pkg: FSM state enum (IDLE/RUN/DONE), default POLY/XOROUT constants, and the serial-step function used by the bench model.
- One sub-module: lfsr_galois_p, the combinational N-bit Galois step (lfsr_in, data -> lfsr_out) parameterised by WIDTH/N/POLY. This block adds only the register, FSM, counter and handshakes.

## Test plan
- Seed 0, one beat s_data=16'h0000 with last → crc_out=16'h0000, crc_valid 2 cycles after start, beat_cnt=1.
- Seed 0, one beat s_data=16'h0001 with last → crc_out=16'h6801.
- Seed 16'hFFFF, 64 random beats back-to-back, last on beat 64 → crc_out matches lfsr_pkg serial model, beat_cnt=64, s_ready never drops in RUN.
- crc_ready held low 10 cycles in DONE → crc_valid and crc_out stable, start pulses ignored, s_ready=0. Release crc_ready → IDLE next cycle.
- abort asserted on beat 5 with s_valid=1 → beat not counted (beat_cnt=4), IDLE next cycle, no crc_valid. Following packet with seed 0 and data 16'h0001 still gives 16'h6801.
- rst_b pulsed low mid-RUN (asynchronous, between edges) → outputs reach reset values without a clock edge. Following packet behaves as after power-up.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR/CRC sequencing controller.
//   - state_e      : controller FSM states
//   - DEF_*        : default width, beat size, polynomial and output mask
//   - lfsr_step_bit: one serial Galois step (one data bit into the register)
package lfsr_pkg;

    localparam int              DEF_WIDTH  = 16;
    localparam int              DEF_N      = 16;
    localparam logic [15:0]     DEF_POLY   = 16'h6801;
    localparam logic [15:0]     DEF_XOROUT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Data bit enters at the top of the register, the bit shifted out
    // decides whether the taps are folded back in.
    function automatic logic [DEF_WIDTH-1:0] lfsr_step_bit(
        input logic [DEF_WIDTH-1:0] s,
        input logic                 d,
        input logic [DEF_WIDTH-1:0] poly
    );
        logic fb;
        fb = s[DEF_WIDTH-1] ^ d;
        return {s[DEF_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/lfsr_crc_ctrl_if.sv
// Handshake bundle between a packet source / CRC consumer and the controller.
//   start/seed/abort        : packet control from the source
//   s_valid/s_ready/s_data/s_last : data beat stream
//   crc_valid/crc_ready/crc_out   : signature hand-off
//   beat_cnt                : beats accepted in current/last packet
// master = source/consumer side, slave = controller side.
interface lfsr_crc_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int N     = 16
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic [N-1:0]     s_data;
    logic             s_last;
    logic             crc_valid;
    logic             crc_ready;
    logic [WIDTH-1:0] crc_out;
    logic [15:0]      beat_cnt;

    modport master (
        output start, seed, abort, s_valid, s_data, s_last, crc_ready,
        input  s_ready, crc_valid, crc_out, beat_cnt
    );

    modport slave (
        input  start, seed, abort, s_valid, s_data, s_last, crc_ready,
        output s_ready, crc_valid, crc_out, beat_cnt
    );
endinterface

// File: rtl/lfsr_galois_p.sv
// Combinational N-bit parallel Galois LFSR step.
//   lfsr_in  : current register value
//   data     : N data bits, data[N-1] consumed first
//   lfsr_out : register value after N serial steps
module lfsr_galois_p #(
    parameter int               WIDTH = 16,
    parameter int               N     = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h6801
) (
    input  logic [WIDTH-1:0] lfsr_in,
    input  logic [N-1:0]     data,
    output logic [WIDTH-1:0] lfsr_out
);

    logic [WIDTH-1:0] acc;
    logic             fb;

    // Unrolled at elaboration into an XOR network; no state is held.
    always_comb begin
        acc = lfsr_in;
        fb  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            fb  = acc[WIDTH-1] ^ data[i];
            acc = {acc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        lfsr_out = acc;
    end

endmodule

// File: rtl/lfsr_crc_ctrl.sv
// Packet sequencing controller around a parallel Galois LFSR step.
// Seeds the register on start, advances it once per accepted beat and holds
// the final signature until the consumer takes it.
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : lfsr_crc_ctrl_if slave modport (control, beat stream, signature)
//
// state | meaning
// IDLE  | waiting for start; no beats accepted, no signature offered
// RUN   | accepting beats, one per cycle, until s_last
// DONE  | signature offered on crc_out until crc_ready
module lfsr_crc_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter int               N      = DEF_N,
    parameter logic [WIDTH-1:0] POLY   = DEF_POLY,
    parameter logic [WIDTH-1:0] XOROUT = DEF_XOROUT
) (
    input logic            clk,
    input logic            rst_b,
    lfsr_crc_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] step_out;
    logic             accept;

    lfsr_galois_p #(
        .WIDTH (WIDTH),
        .N     (N),
        .POLY  (POLY)
    ) u_step (
        .lfsr_in  (lfsr_q),
        .data     (bus.s_data),
        .lfsr_out (step_out)
    );

    // abort masks s_ready so a beat offered alongside it is never taken.
    assign bus.s_ready   = (state_q == ST_RUN) && !bus.abort;
    assign bus.crc_valid = (state_q == ST_DONE);
    assign bus.crc_out   = lfsr_q ^ XOROUT;
    assign bus.beat_cnt  = cnt_q;
    assign accept        = bus.s_ready && bus.s_valid;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.abort && bus.start) begin
                    lfsr_d  = bus.seed;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    lfsr_d = step_out;
                    cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    if (bus.s_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.crc_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
